dmem_bus_ctrl: RTL and testbench

- Data-memory bus controller directly downstream of the ME stage.
- Consumes ME's memory request (chip enable, write enable, byte selects, address, write data) and runs a registered request/acknowledge bus transaction to data memory or peripherals.
- Returns the read word to ME and raises a stall request while the access is outstanding.
- Adds a bounded-wait timeout so a missing slave cannot hang the core.

---
 rtl/dmem_bus_ctrl_pkg.sv | 27 ++
 rtl/dmem_bus_ctrl_if.sv | 32 +++
 rtl/dmem_bus_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_bus_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_bus_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_bus_ctrl_pkg
// Brief    : Shared encodings and constants for the data-memory bus controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        DBC_IDLE = 2'b00,
        DBC_WAIT = 2'b01,
        DBC_DONE = 2'b10
    } dbc_state_e;

    localparam logic [3:0]  c_bus_sel_all  = 4'b1111;
    localparam logic [31:0] c_zero_word    = 32'h0000_0000;
    localparam logic        c_chip_enable  = 1'b1;
    localparam logic        c_write_enable = 1'b1;

    // Loads always fetch the whole word; ME picks the lane afterwards.
    function automatic logic [3:0] bus_sel_for(input logic we, input logic [3:0] sel);
        return (we == c_write_enable) ? sel : c_bus_sel_all;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_bus_if
// Brief    : Request/acknowledge data-memory bus between controller and slave.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cyc;
    logic              stb;
    logic              we;
    logic [3:0]        sel;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] wdat;
    logic [DATA_W-1:0] rdat;
    logic              ack;
    logic              err;

    modport master (
        output cyc, stb, we, sel, adr, wdat, err,
        input  rdat, ack
    );

    modport slave (
        input  cyc, stb, we, sel, adr, wdat, err,
        output rdat, ack
    );
endinterface
`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : dmem_bus_ctrl
// Brief    : ME-stage data-memory bus controller with registered bus outputs,
//            pipeline stall request and bounded-wait timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bus_ctrl
    import dmem_bus_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              mem_ce_i,
    input  wire logic              mem_w_enable_i,
    input  wire logic [3:0]        mem_sel_i,
    input  wire logic [ADDR_W-1:0] mem_addr_i,
    input  wire logic [DATA_W-1:0] mem_w_data_i,
    output logic      [DATA_W-1:0] mem_r_data_o,
    output logic                   stall_req_o,
    dmem_bus_if.master             bus
);

    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] c_zero     = DATA_W'(c_zero_word);
    localparam logic [ADDR_W-1:0] c_adr_mask = ~ADDR_W'(3);

    dbc_state_e        r_state, w_state_nxt;
    logic              r_cyc,   w_cyc_nxt;
    logic              r_we,    w_we_nxt;
    logic [3:0]        r_sel,   w_sel_nxt;
    logic [ADDR_W-1:0] r_adr,   w_adr_nxt;
    logic [DATA_W-1:0] r_wdat,  w_wdat_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic              r_err,   w_err_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DBC_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 4'b0000;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_sel   <= w_sel_nxt;
            r_adr   <= w_adr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_rdata <= w_rdata_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_we_nxt    = r_we;
        w_sel_nxt   = r_sel;
        w_adr_nxt   = r_adr;
        w_wdat_nxt  = r_wdat;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = 1'b0;

        case (r_state)
            DBC_IDLE: begin
                if (mem_ce_i == c_chip_enable) begin
                    w_cyc_nxt   = 1'b1;
                    w_we_nxt    = mem_w_enable_i;
                    w_sel_nxt   = bus_sel_for(mem_w_enable_i, mem_sel_i);
                    w_adr_nxt   = mem_addr_i & c_adr_mask;
                    w_wdat_nxt  = mem_w_data_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = DBC_WAIT;
                end
            end

            DBC_WAIT: begin
                w_cnt_nxt = r_cnt + 1'b1;
                // Ack is checked first so an ack on the last allowed cycle is not an error.
                if (bus.ack) begin
                    w_rdata_nxt = (r_we == c_write_enable) ? c_zero : bus.rdat;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_state_nxt = DBC_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_rdata_nxt = c_zero;
                    w_cyc_nxt   = 1'b0;
                    w_we_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DBC_DONE;
                end
            end

            DBC_DONE: begin
                w_state_nxt = DBC_IDLE;
            end

            default: begin
                w_state_nxt = DBC_IDLE;
            end
        endcase
    end

    // One-cycle stall release in DONE lets ME retire the access with valid data.
    assign stall_req_o  = ((r_state == DBC_IDLE) && mem_ce_i) || (r_state == DBC_WAIT);
    assign mem_r_data_o = (r_state == DBC_DONE) ? r_rdata : c_zero;

    assign bus.cyc  = r_cyc;
    assign bus.stb  = r_cyc;
    assign bus.we   = r_we;
    assign bus.sel  = r_sel;
    assign bus.adr  = r_adr;
    assign bus.wdat = r_wdat;
    assign bus.err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_dmem_bus_ctrl
// Brief    : Self-checking bench for dmem_bus_ctrl with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'b0000;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        stall;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_bus_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    dmem_bus_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .CNT_W(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ce_i       (mem_ce),
        .mem_w_enable_i (mem_we),
        .mem_sel_i      (mem_sel),
        .mem_addr_i     (mem_addr),
        .mem_w_data_i   (mem_wdata),
        .mem_r_data_o   (mem_rdata),
        .stall_req_o    (stall),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    // ack_at = WAIT cycle (1-based) on which the slave acks; 0 = never.
    task automatic run_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdat,
                              input int ack_at, input bit hold_ce);
        exp_t e;
        int   waits;
        int   exp_waits;
        bit   acked;
        acked     = (ack_at >= 1) && (ack_at <= TO);
        e.rdata   = (acked && !we) ? rdat : 32'h0;
        e.err     = !acked;
        exp_waits = acked ? ack_at : TO;
        mem_ce    = 1'b1;
        mem_we    = we;
        mem_sel   = sel;
        mem_addr  = addr;
        mem_wdata = wdata;
        sb_q.push_back(e);
        #1;
        chk("stall_idle", 32'(stall), 32'd1);
        chk("cyc_idle", 32'(bus_if.cyc), 32'd0);
        @(negedge clk);
        waits = 0;
        while (stall && waits < 20) begin
            waits++;
            chk("cyc", 32'(bus_if.cyc), 32'd1);
            chk("stb", 32'(bus_if.stb), 32'd1);
            chk("we", 32'(bus_if.we), 32'(we));
            chk("sel", 32'(bus_if.sel), we ? 32'(sel) : 32'hF);
            chk("adr", bus_if.adr, {addr[31:2], 2'b00});
            chk("wdat", bus_if.wdat, wdata);
            if (waits == ack_at) begin
                bus_if.ack  = 1'b1;
                bus_if.rdat = rdat;
            end
            @(negedge clk);
            bus_if.ack  = 1'b0;
            bus_if.rdat = 32'hDEAD_BEEF;
        end
        chk("wait_cycles", 32'(waits), 32'(exp_waits));
        chk("cyc_done", 32'(bus_if.cyc), 32'd0);
        chk("stb_done", 32'(bus_if.stb), 32'd0);
        chk("we_done", 32'(bus_if.we), 32'd0);
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk("rdata_done", mem_rdata, e.rdata);
            chk("err_done", 32'(bus_if.err), 32'(e.err));
        end
        if (!hold_ce) mem_ce = 1'b0;
        @(negedge clk);
        chk("err_clear", 32'(bus_if.err), 32'd0);
        chk("rdata_idle", mem_rdata, 32'd0);
        chk("stall_after", 32'(stall), 32'(hold_ce));
    endtask

    initial begin
        bus_if.ack  = 1'b0;
        bus_if.rdat = 32'hDEAD_BEEF;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cyc", 32'(bus_if.cyc), 32'd0);
        chk("rst_stb", 32'(bus_if.stb), 32'd0);
        chk("rst_we", 32'(bus_if.we), 32'd0);
        chk("rst_sel", 32'(bus_if.sel), 32'd0);
        chk("rst_adr", bus_if.adr, 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait load, unaligned address
        run_access(1'b0, 4'b0000, 32'h0000_1006, 32'h0, 32'hA1B2C3D4, 1, 1'b0);
        // Byte store acked on the 4th WAIT cycle (also the last cycle before timeout)
        run_access(1'b1, 4'b0100, 32'h0000_2002, 32'h5A5A5A5A, 32'h0, 4, 1'b0);
        // Missing slave: timeout abort
        run_access(1'b0, 4'b0000, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);
        // Load acked on the exact timeout cycle
        run_access(1'b0, 4'b0000, 32'h0000_3008, 32'h0, 32'hCAFEF00D, TO, 1'b0);
        // Back-to-back loads with ce held high
        run_access(1'b0, 4'b0000, 32'h0000_0100, 32'h0, 32'h11111111, 2, 1'b1);
        run_access(1'b0, 4'b0000, 32'h0000_0104, 32'h0, 32'h22222222, 1, 1'b0);
        // Store of full word after a timeout-free load
        run_access(1'b1, 4'b1111, 32'h0000_0040, 32'h87654321, 32'h0, 2, 1'b0);

        // Asynchronous reset in the middle of WAIT
        mem_ce    = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 4'b0011;
        mem_addr  = 32'h0000_0080;
        mem_wdata = 32'h12345678;
        @(negedge clk);
        chk("pre_rst_cyc", 32'(bus_if.cyc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", 32'(bus_if.cyc), 32'd0);
        chk("arst_stb", 32'(bus_if.stb), 32'd0);
        chk("arst_we", 32'(bus_if.we), 32'd0);
        chk("arst_sel", 32'(bus_if.sel), 32'd0);
        chk("arst_adr", bus_if.adr, 32'd0);
        mem_ce = 1'b0;
        #1;
        chk("arst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_cyc", 32'(bus_if.cyc), 32'd0);

        // Normal operation resumes after the abandoned cycle
        run_access(1'b0, 4'b0000, 32'h0000_0200, 32'h0, 32'h0BADF00D, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
